led_seq_ctrl: RTL and testbench

- Controller that sequences the LED shift-register datapath and is configured over the UART byte stream.
- Decodes single-byte ASCII commands from the UART receiver: run, pause, single-step, direction toggle, rate select and status query.
- Generates the one-cycle shift strobe (o_valid) and the direction level (o_sw) that feed the shift register's i_valid/i_sw inputs.
- Returns a status byte to the UART transmitter over a valid/ready handshake.

---
 rtl/led_seq_pkg.sv | 47 ++++
 rtl/led_seq_ctrl_if.sv | 21 ++
 rtl/led_tick_gen.sv | 30 +++
 rtl/led_seq_ctrl.sv | 111 +++++++++++
 tb/tb_led_seq_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared command codes, state encoding and decode helpers for the LED sequencer controller.
package led_seq_pkg;

  localparam logic [7:0] CMD_RUN       = 8'h52;
  localparam logic [7:0] CMD_PAUSE     = 8'h50;
  localparam logic [7:0] CMD_STEP      = 8'h53;
  localparam logic [7:0] CMD_DIR       = 8'h44;
  localparam logic [7:0] CMD_RATE_BASE = 8'h30;
  localparam logic [7:0] CMD_STATUS    = 8'h3F;

  localparam logic [3:0] STATUS_TAG = 4'hA;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_RUN,
    OP_PAUSE,
    OP_STEP,
    OP_DIR,
    OP_RATE,
    OP_STATUS,
    OP_BAD
  } op_t;

  // Rate commands occupy 0x30..0x33: everything above bit 1 must match the base.
  function automatic op_t decode_cmd(input logic [7:0] cmd);
    op_t op;
    case (cmd)
      CMD_RUN:    op = OP_RUN;
      CMD_PAUSE:  op = OP_PAUSE;
      CMD_STEP:   op = OP_STEP;
      CMD_DIR:    op = OP_DIR;
      CMD_STATUS: op = OP_STATUS;
      default:    op = (cmd[7:2] == CMD_RATE_BASE[7:2]) ? OP_RATE : OP_BAD;
    endcase
    return op;
  endfunction

  function automatic logic [7:0] status_byte(input state_t st, input logic dir,
                                             input logic [1:0] rate);
    return {STATUS_TAG, (st == ST_RUN), dir, rate};
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// UART byte-stream handshake between the controller and the UART RX/TX blocks.
interface led_seq_ctrl_if #(
    parameter int unsigned NB_DATA = 8
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_ready,
        output o_rx_ready, o_tx_data, o_tx_valid
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_ready,
        input  o_rx_ready, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: counts while enabled and flags the terminal count, wrapping to zero there.
module led_tick_gen #(
    parameter int unsigned NB_COUNTER = 27
) (
    input  logic                  clock,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_clear,
    input  logic [NB_COUNTER-1:0] i_limit,
    output logic                  o_tick
);

    logic [NB_COUNTER-1:0] r_count;
    logic                  w_terminal;

    // >= rather than == so a shrinking limit can never strand the counter above it.
    assign w_terminal = (r_count >= i_limit);
    assign o_tick     = i_enable && w_terminal;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_terminal ? '0 : r_count + NB_COUNTER'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: decodes UART command bytes, paces the shift strobe and
// answers status queries.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_COUNTER = 27,
    parameter int unsigned LIMIT_0    = 99_999_999,
    parameter int unsigned LIMIT_1    = 49_999_999,
    parameter int unsigned LIMIT_2    = 24_999_999,
    parameter int unsigned LIMIT_3    = 12_499_999
) (
    input  logic                 clock,
    input  logic                 i_reset_n,
    led_seq_ctrl_if.slave        u_uart,
    output logic                 o_valid,
    output logic                 o_sw,
    output logic                 o_err
);

    state_t                r_state;
    logic [1:0]            r_rate;
    logic                  r_dir;
    logic                  r_valid;
    logic                  r_sw;
    logic                  r_err;
    logic                  r_tx_valid;
    logic [NB_DATA-1:0]    r_tx_data;

    logic [7:0]            w_byte;
    op_t                   w_op;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_step;
    logic                  w_rate_clear;
    logic [NB_COUNTER-1:0] w_limit;

    assign w_byte       = 8'(u_uart.i_rx_data);
    assign w_op         = decode_cmd(w_byte);
    // A pending reply blocks intake so the status byte cannot be overwritten.
    assign w_accept     = u_uart.i_rx_valid && !r_tx_valid;
    assign w_step       = w_accept && (w_op == OP_STEP) && (r_state == ST_PAUSE);
    assign w_rate_clear = w_accept && (w_op == OP_RATE);

    always_comb begin
        w_limit = NB_COUNTER'(LIMIT_0);
        case (r_rate)
            2'd1:    w_limit = NB_COUNTER'(LIMIT_1);
            2'd2:    w_limit = NB_COUNTER'(LIMIT_2);
            2'd3:    w_limit = NB_COUNTER'(LIMIT_3);
            default: w_limit = NB_COUNTER'(LIMIT_0);
        endcase
    end

    led_tick_gen #(
        .NB_COUNTER(NB_COUNTER)
    ) u_tick_gen (
        .clock    (clock),
        .i_reset_n(i_reset_n),
        .i_enable (r_state == ST_RUN),
        .i_clear  (w_rate_clear),
        .i_limit  (w_limit),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_RUN;
            r_rate     <= '0;
            r_dir      <= 1'b0;
            r_valid    <= 1'b0;
            r_sw       <= 1'b0;
            r_err      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            // Tick uses the pre-command state, so a pause on terminal count still strobes.
            r_valid <= w_tick || w_step;
            r_err   <= w_accept && (w_op == OP_BAD);

            if (r_tx_valid && u_uart.i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            if (w_accept) begin
                case (w_op)
                    OP_RUN:   r_state <= ST_RUN;
                    OP_PAUSE: r_state <= ST_PAUSE;
                    OP_DIR: begin
                        r_dir <= ~r_dir;
                        r_sw  <= ~r_dir;
                    end
                    OP_RATE:  r_rate <= w_byte[1:0];
                    OP_STATUS: begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= NB_DATA'(status_byte(r_state, r_dir, r_rate));
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_valid           = r_valid;
    assign o_sw              = r_sw;
    assign o_err             = r_err;
    assign u_uart.o_rx_ready = !r_tx_valid;
    assign u_uart.o_tx_valid = r_tx_valid;
    assign u_uart.o_tx_data  = r_tx_data;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with shortened prescaler limits and a per-cycle model.
module tb_led_seq_ctrl;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic o_valid, o_sw, o_err;

    led_seq_ctrl_if #(.NB_DATA(8)) u_if ();

    led_seq_ctrl #(
        .NB_DATA   (8),
        .NB_COUNTER(27),
        .LIMIT_0   (7),
        .LIMIT_1   (3),
        .LIMIT_2   (1),
        .LIMIT_3   (0)
    ) dut (
        .clock    (clock),
        .i_reset_n(rst_n),
        .u_uart   (u_if),
        .o_valid  (o_valid),
        .o_sw     (o_sw),
        .o_err    (o_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: run-cycle count since the last strobe or rate change, plus reply bookkeeping.
    int         lim[4] = '{7, 3, 1, 0};
    bit         m_run = 1'b1;
    int         m_rate = 0;
    bit         m_dir = 1'b0;
    int         m_runcycles = 0;
    bit         m_pending = 1'b0;
    int         m_reply = 0;
    bit         e_valid = 1'b0;
    bit         e_err = 1'b0;
    bit         m_acc;
    bit         m_periodic;
    logic [7:0] m_b;

    task automatic model_step();
        if (!rst_n) begin
            m_run = 1'b1; m_rate = 0; m_dir = 1'b0; m_runcycles = 0;
            m_pending = 1'b0; m_reply = 0; e_valid = 1'b0; e_err = 1'b0;
        end else begin
            m_acc      = u_if.i_rx_valid && !m_pending;
            m_b        = u_if.i_rx_data;
            m_periodic = m_run && (m_runcycles == lim[m_rate]);
            e_valid    = m_periodic || (m_acc && m_b == 8'h53 && !m_run);
            e_err      = m_acc && !(m_b inside {8'h52, 8'h50, 8'h53, 8'h44, 8'h3F, [8'h30:8'h33]});
            if (m_periodic) m_runcycles = 0;
            else if (m_run) m_runcycles++;
            if (m_pending && u_if.i_tx_ready) m_pending = 1'b0;
            if (m_acc) begin
                case (m_b)
                    8'h52: m_run = 1'b1;
                    8'h50: m_run = 1'b0;
                    8'h44: m_dir = !m_dir;
                    8'h3F: begin
                        m_pending = 1'b1;
                        m_reply   = 8'hA0 + (m_run ? 8 : 0) + (m_dir ? 4 : 0) + m_rate;
                    end
                    8'h30, 8'h31, 8'h32, 8'h33: begin
                        m_rate      = int'(m_b) - 8'h30;
                        m_runcycles = 0;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    always @(posedge clock or negedge rst_n) model_step();

    always @(negedge clock) begin
        chk("cyc_valid",    o_valid,          e_valid);
        chk("cyc_sw",       o_sw,             m_dir);
        chk("cyc_err",      o_err,            e_err);
        chk("cyc_tx_valid", u_if.o_tx_valid,  m_pending);
        chk("cyc_rx_ready", u_if.o_rx_ready,  !m_pending);
        if (m_pending) chk("cyc_tx_data", u_if.o_tx_data, m_reply);
    end

    task automatic step1();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        u_if.i_rx_data  = b;
        u_if.i_rx_valid = 1'b1;
        step1();
        u_if.i_rx_valid = 1'b0;
    endtask

    task automatic cycles_to_strobe(output int n);
        n = 0;
        do begin
            step1();
            n++;
        end while (!o_valid && n < 20);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    o_valid,         0);
        chk({tag, "_sw"},       o_sw,            0);
        chk({tag, "_err"},      o_err,           0);
        chk({tag, "_tx_valid"}, u_if.o_tx_valid, 0);
        chk({tag, "_rx_ready"}, u_if.o_rx_ready, 1);
        chk({tag, "_tx_data"},  u_if.o_tx_data,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        u_if.i_rx_data  = 8'h00;
        u_if.i_rx_valid = 1'b0;
        u_if.i_tx_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        cycles_to_strobe(n); chk("first_strobe_gap", n, 8);
        cycles_to_strobe(n); chk("rate0_period", n, 8);

        send(8'h32);
        chk("rate2_accept_no_strobe", o_valid, 0);
        cycles_to_strobe(n); chk("rate2_first", n, 2);
        cycles_to_strobe(n); chk("rate2_period", n, 2);

        send(8'h50);
        cnt = 0;
        repeat (10) begin
            step1();
            if (o_valid) cnt++;
        end
        chk("pause_no_strobe", cnt, 0);
        send(8'h53); chk("step1_pulse", o_valid, 1);
        step1();     chk("step1_single", o_valid, 0);
        send(8'h53); chk("step2_pulse", o_valid, 1);
        step1();     chk("step2_single", o_valid, 0);

        send(8'h44); chk("dir_sw", o_sw, 1);

        u_if.i_tx_ready = 1'b0;
        send(8'h3F);
        chk("status_valid", u_if.o_tx_valid, 1);
        chk("status_data",  u_if.o_tx_data,  8'hA6);
        chk("status_block", u_if.o_rx_ready, 0);
        u_if.i_rx_data  = 8'h44;
        u_if.i_rx_valid = 1'b1;
        repeat (5) begin
            step1();
            chk("hold_tx_valid", u_if.o_tx_valid, 1);
            chk("hold_rx_ready", u_if.o_rx_ready, 0);
            chk("hold_not_consumed_sw", o_sw, 1);
        end
        u_if.i_rx_valid = 1'b0;
        u_if.i_tx_ready = 1'b1;
        step1();
        chk("release_tx_valid", u_if.o_tx_valid, 0);
        chk("release_rx_ready", u_if.o_rx_ready, 1);
        chk("release_sw",       o_sw,            1);

        send(8'h7A); chk("err_pulse", o_err, 1);
        step1();     chk("err_single", o_err, 0);
        send(8'h3F); chk("status_after_err", u_if.o_tx_data, 8'hA6);
        step1();     chk("status_consumed", u_if.o_tx_valid, 0);

        send(8'h52);
        send(8'h30);
        repeat (5) step1();
        send(8'h31);
        cycles_to_strobe(n); chk("shrink_rate_first", n, 4);

        send(8'h33);
        step1(); chk("rate3_strobe_a", o_valid, 1);
        step1(); chk("rate3_strobe_b", o_valid, 1);
        send(8'h50); chk("pause_on_terminal_strobe", o_valid, 1);
        step1();     chk("pause_on_terminal_after", o_valid, 0);

        send(8'h52); chk("resume_no_strobe_yet", o_valid, 0);
        step1();     chk("resume_rate3_strobe", o_valid, 1);
        send(8'h31); chk("rate_on_terminal_strobe", o_valid, 1);
        cycles_to_strobe(n); chk("rate_on_terminal_restart", n, 4);

        u_if.i_tx_ready = 1'b0;
        send(8'h3F);
        chk("midreply_pending", u_if.o_tx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreply_reset");
        u_if.i_tx_ready = 1'b1;
        step1();
        rst_n = 1'b1;
        repeat (12) step1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
